// File: rtl/peripheral_bus_fabric_pkg.sv
// Shared definitions for the peripheral-bus return-path fabric.
// Holds the fabric state encoding, the default data width, the default
// error read value, and the width of the saturating error counter.
package peripheral_bus_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        DONE    = 2'd2,
        TIMEOUT = 2'd3
    } fabric_state_t;

    localparam int               DEFAULT_DATA_WIDTH = 32;
    localparam logic [31:0]      DEFAULT_ERROR_DATA = 32'hDEAD_BEEF;
    localparam int               ERR_CNT_W          = 8;

endpackage

// File: rtl/peripheral_bus_fabric_if.sv
// Peripheral-bus handshake between the Wishbone bus interface (master)
// and the return-path fabric (slave).
//   peripheralBus_we / _oe   : write / read strobes, held until busy is low
//   peripheralBus_busy       : combined busy back to the bus interface
//   peripheralBus_dataRead   : muxed read data
//   bus_error                : transaction ended with an error (valid when busy low)
interface peripheral_bus_fabric_if
    import peripheral_bus_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);
    logic                  peripheralBus_we;
    logic                  peripheralBus_oe;
    logic                  peripheralBus_busy;
    logic [DATA_WIDTH-1:0] peripheralBus_dataRead;
    logic                  bus_error;

    modport master (
        output peripheralBus_we,
        output peripheralBus_oe,
        input  peripheralBus_busy,
        input  peripheralBus_dataRead,
        input  bus_error
    );

    modport slave (
        input  peripheralBus_we,
        input  peripheralBus_oe,
        output peripheralBus_busy,
        output peripheralBus_dataRead,
        output bus_error
    );
endinterface

// File: rtl/peripheral_bus_fabric_priority_claim_mux.sv
// Combinational priority mux over the device read claims.
//   claim       : per-device read claim
//   data_flat   : per-device read data, device i at [i*DATA_WIDTH +: DATA_WIDTH]
//   sel         : lowest index with its claim set (0 when none)
//   any_claim   : at least one claim
//   multi_claim : more than one claim
//   data        : read data of the selected device (0 when none)
module priority_claim_mux
    import peripheral_bus_pkg::*;
#(
    parameter int DEVICE_COUNT = 2,
    parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter int SEL_W        = (DEVICE_COUNT > 1) ? $clog2(DEVICE_COUNT) : 1
)(
    input  logic [DEVICE_COUNT-1:0]            claim,
    input  logic [DEVICE_COUNT*DATA_WIDTH-1:0] data_flat,
    output logic [SEL_W-1:0]                   sel,
    output logic                               any_claim,
    output logic                               multi_claim,
    output logic [DATA_WIDTH-1:0]              data
);
    always_comb begin
        sel  = '0;
        data = '0;
        // Scan from the top down so the lowest claiming index wins.
        for (int i = DEVICE_COUNT - 1; i >= 0; i--) begin
            if (claim[i]) begin
                sel  = SEL_W'(i);
                data = data_flat[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        any_claim   = |claim;
        // Clearing the lowest set bit leaves something only if two or more were set.
        multi_claim = |(claim & (claim - DEVICE_COUNT'(1)));
    end
endmodule

// File: rtl/peripheral_bus_fabric.sv
// Return-path fabric between the peripheral-bus interface and N devices.
// Combines device busy, muxes read data by lowest claiming index, tracks
// each transaction with a busy timeout, flags reads nobody claims, flags
// multi-device claims, and counts error events with saturation.
//   clk, rst              : clock, asynchronous active-high reset
//   bus                   : peripheral-bus handshake (slave side)
//   device_busy           : per-device busy
//   device_requestOutput  : per-device read claim
//   device_dataRead       : per-device read data, device i at [i*DATA_WIDTH +: DATA_WIDTH]
//   clear_status          : synchronous clear of conflict and error_count
//   conflict              : sticky, set when several devices claim during a strobe
//   error_count           : saturating count of decode errors and timeouts
module peripheral_bus_fabric
    import peripheral_bus_pkg::*;
#(
    parameter int                    DEVICE_COUNT   = 2,
    parameter int                    DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int                    TIMEOUT_CYCLES = 64,
    parameter logic [DATA_WIDTH-1:0] ERROR_DATA     = DATA_WIDTH'(DEFAULT_ERROR_DATA)
)(
    input  logic                               clk,
    input  logic                               rst,
    peripheral_bus_fabric_if.slave             bus,
    input  logic [DEVICE_COUNT-1:0]            device_busy,
    input  logic [DEVICE_COUNT-1:0]            device_requestOutput,
    input  logic [DEVICE_COUNT*DATA_WIDTH-1:0] device_dataRead,
    input  logic                               clear_status,
    output logic                               conflict,
    output logic [ERR_CNT_W-1:0]               error_count
);
    localparam int SEL_W   = (DEVICE_COUNT > 1) ? $clog2(DEVICE_COUNT) : 1;
    localparam int TIMER_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    fabric_state_t         state, state_next;
    logic [TIMER_W-1:0]    timer, timer_next;
    logic                  strobe, any_busy, complete, decode_err, err_inc;
    logic                  any_claim, multi_claim;
    logic [SEL_W-1:0]      sel;
    logic [DATA_WIDTH-1:0] mux_data;
    logic                  busy_out, error_out;
    logic [DATA_WIDTH-1:0] data_out;

    priority_claim_mux #(
        .DEVICE_COUNT (DEVICE_COUNT),
        .DATA_WIDTH   (DATA_WIDTH),
        .SEL_W        (SEL_W)
    ) u_mux (
        .claim       (device_requestOutput),
        .data_flat   (device_dataRead),
        .sel         (sel),
        .any_claim   (any_claim),
        .multi_claim (multi_claim),
        .data        (mux_data)
    );

    assign strobe     = bus.peripheralBus_we | bus.peripheralBus_oe;
    assign any_busy   = |device_busy;
    assign complete   = strobe & ~any_busy;
    assign decode_err = complete & bus.peripheralBus_oe & ~any_claim;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            timer       <= '0;
            conflict    <= 1'b0;
            error_count <= '0;
        end else begin
            state <= state_next;
            timer <= timer_next;
            // Clear wins over a set/increment landing on the same edge.
            if (clear_status) begin
                conflict    <= 1'b0;
                error_count <= '0;
            end else begin
                if (strobe && multi_claim) conflict <= 1'b1;
                if (err_inc) error_count <= sat_inc(error_count);
            end
        end
    end

    always_comb begin
        state_next = state;
        timer_next = timer;
        busy_out   = 1'b0;
        error_out  = 1'b0;
        data_out   = '0;
        err_inc    = 1'b0;

        unique case (state)
            IDLE, ACTIVE: begin
                busy_out = any_busy;
                data_out = any_claim ? mux_data : '0;
                if (decode_err) begin
                    error_out = 1'b1;
                    data_out  = ERROR_DATA;
                    err_inc   = 1'b1;
                end
                if (state == IDLE) begin
                    if (strobe && any_busy) begin
                        state_next = ACTIVE;
                        timer_next = TIMER_W'(1);
                    end else if (strobe) begin
                        state_next = DONE;
                    end
                end else if (!strobe) begin
                    // Master abort: drop back quietly.
                    state_next = IDLE;
                    timer_next = '0;
                end else if (any_busy) begin
                    if (timer == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
                        state_next = TIMEOUT;
                        err_inc    = 1'b1;
                    end else begin
                        timer_next = timer + 1'b1;
                    end
                end else begin
                    state_next = DONE;
                    timer_next = '0;
                end
            end
            DONE: begin
                if (!strobe) state_next = IDLE;
            end
            TIMEOUT: begin
                // Device busy is masked so the master is released with an error.
                error_out = 1'b1;
                data_out  = ERROR_DATA;
                if (!strobe) begin
                    state_next = IDLE;
                    timer_next = '0;
                end
            end
            default: state_next = IDLE;
        endcase

        if (rst) begin
            busy_out  = 1'b0;
            error_out = 1'b0;
            data_out  = '0;
        end
    end

    assign bus.peripheralBus_busy     = busy_out;
    assign bus.bus_error              = error_out;
    assign bus.peripheralBus_dataRead = data_out;
endmodule

// File: tb/tb_peripheral_bus_fabric.sv
module tb_peripheral_bus_fabric;
    localparam int N  = 4;
    localparam int DW = 32;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  device_busy;
    logic [N-1:0]  device_requestOutput;
    logic [N*DW-1:0] device_dataRead;
    logic          clear_status;
    logic          conflict;
    logic [7:0]    error_count;

    int n_checks = 0;
    int n_fail   = 0;

    peripheral_bus_fabric_if #(.DATA_WIDTH(DW)) bus ();

    peripheral_bus_fabric #(
        .DEVICE_COUNT   (N),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO),
        .ERROR_DATA     (32'hDEAD_BEEF)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .bus                  (bus),
        .device_busy          (device_busy),
        .device_requestOutput (device_requestOutput),
        .device_dataRead      (device_dataRead),
        .clear_status         (clear_status),
        .conflict             (conflict),
        .error_count          (error_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_dev(input int idx, input logic [DW-1:0] val);
        device_dataRead[idx*DW +: DW] = val;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.peripheralBus_we = 1'b0;
        bus.peripheralBus_oe = 1'b0;
        clear_status = 1'b0;
        device_busy = 4'b1111;
        device_requestOutput = 4'b0001;
        device_dataRead = '0;
        set_dev(0, 32'hAAAA_5555);
        tick();
        @(negedge clk);
        n_checks++; if (bus.peripheralBus_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.peripheralBus_busy); end
        n_checks++; if (bus.peripheralBus_dataRead !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 00000000", bus.peripheralBus_dataRead); end
        n_checks++; if (bus.bus_error !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", bus.bus_error); end
        n_checks++; if (conflict !== 1'b0) begin n_fail++; $display("FAIL reset_conflict: got %b expected 0", conflict); end
        n_checks++; if (error_count !== 8'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", error_count); end
        tick();
        rst = 1'b0;
        device_busy = '0;
        device_requestOutput = '0;
        tick();
    endtask

    task automatic test_single_read();
        tick();
        bus.peripheralBus_oe = 1'b1;
        device_requestOutput = 4'b0100;
        set_dev(2, 32'h1234_5678);
        @(negedge clk);
        n_checks++; if (bus.peripheralBus_busy !== 1'b0) begin n_fail++; $display("FAIL single_busy: got %b expected 0", bus.peripheralBus_busy); end
        n_checks++; if (bus.peripheralBus_dataRead !== 32'h1234_5678) begin n_fail++; $display("FAIL single_data: got %h expected 12345678", bus.peripheralBus_dataRead); end
        n_checks++; if (bus.bus_error !== 1'b0) begin n_fail++; $display("FAIL single_err: got %b expected 0", bus.bus_error); end
        // Held strobe in DONE: a device going busy must not re-open a transaction.
        tick();
        device_busy = 4'b0001;
        @(negedge clk);
        n_checks++; if (bus.peripheralBus_busy !== 1'b0) begin n_fail++; $display("FAIL done_ignores_busy: got %b expected 0", bus.peripheralBus_busy); end
        tick();
        bus.peripheralBus_oe = 1'b0;
        device_busy = '0;
        device_requestOutput = '0;
    endtask

    task automatic test_multi_read();
        tick();
        bus.peripheralBus_oe = 1'b1;
        device_busy = 4'b0010;
        for (int k = 1; k <= 5; k++) begin
            if (k > 1) tick();
            @(negedge clk);
            n_checks++; if (bus.peripheralBus_busy !== 1'b1) begin n_fail++; $display("FAIL multi_busy_c%0d: got %b expected 1", k, bus.peripheralBus_busy); end
        end
        tick();
        device_busy = '0;
        device_requestOutput = 4'b0010;
        set_dev(1, 32'hCAFE_0001);
        @(negedge clk);
        n_checks++; if (bus.peripheralBus_busy !== 1'b0) begin n_fail++; $display("FAIL multi_done_busy: got %b expected 0", bus.peripheralBus_busy); end
        n_checks++; if (bus.peripheralBus_dataRead !== 32'hCAFE_0001) begin n_fail++; $display("FAIL multi_data: got %h expected cafe0001", bus.peripheralBus_dataRead); end
        n_checks++; if (bus.bus_error !== 1'b0) begin n_fail++; $display("FAIL multi_err: got %b expected 0", bus.bus_error); end
        tick();
        bus.peripheralBus_oe = 1'b0;
        device_requestOutput = '0;
        @(negedge clk);
        n_checks++; if (error_count !== 8'd0) begin n_fail++; $display("FAIL multi_count: got %0d expected 0", error_count); end
    endtask

    task automatic test_timeout();
        tick();
        bus.peripheralBus_oe = 1'b1;
        device_busy = 4'b1000;
        for (int k = 1; k <= TO; k++) begin
            if (k > 1) tick();
            @(negedge clk);
            n_checks++; if (bus.peripheralBus_busy !== 1'b1 || bus.bus_error !== 1'b0) begin n_fail++; $display("FAIL timeout_wait_c%0d: got busy=%b err=%b expected busy=1 err=0", k, bus.peripheralBus_busy, bus.bus_error); end
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            @(negedge clk);
            n_checks++; if (bus.peripheralBus_busy !== 1'b0 || bus.bus_error !== 1'b1) begin n_fail++; $display("FAIL timeout_flags_h%0d: got busy=%b err=%b expected busy=0 err=1", k, bus.peripheralBus_busy, bus.bus_error); end
            n_checks++; if (bus.peripheralBus_dataRead !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL timeout_data_h%0d: got %h expected deadbeef", k, bus.peripheralBus_dataRead); end
            n_checks++; if (error_count !== 8'd1) begin n_fail++; $display("FAIL timeout_count_h%0d: got %0d expected 1", k, error_count); end
        end
        tick();
        bus.peripheralBus_oe = 1'b0;
        device_busy = '0;
        tick();
        @(negedge clk);
        n_checks++; if (bus.bus_error !== 1'b0) begin n_fail++; $display("FAIL timeout_exit_err: got %b expected 0", bus.bus_error); end
    endtask

    task automatic test_decode_error();
        tick();
        bus.peripheralBus_oe = 1'b1;
        device_requestOutput = '0;
        @(negedge clk);
        n_checks++; if (bus.bus_error !== 1'b1) begin n_fail++; $display("FAIL decode_err: got %b expected 1", bus.bus_error); end
        n_checks++; if (bus.peripheralBus_dataRead !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL decode_data: got %h expected deadbeef", bus.peripheralBus_dataRead); end
        n_checks++; if (bus.peripheralBus_busy !== 1'b0) begin n_fail++; $display("FAIL decode_busy: got %b expected 0", bus.peripheralBus_busy); end
        tick();
        @(negedge clk);
        n_checks++; if (error_count !== 8'd2) begin n_fail++; $display("FAIL decode_count: got %0d expected 2", error_count); end
        tick();
        bus.peripheralBus_oe = 1'b0;
        tick();
        bus.peripheralBus_we = 1'b1;
        @(negedge clk);
        n_checks++; if (bus.bus_error !== 1'b0) begin n_fail++; $display("FAIL write_noclaim_err: got %b expected 0", bus.bus_error); end
        n_checks++; if (bus.peripheralBus_dataRead !== 32'h0) begin n_fail++; $display("FAIL write_noclaim_data: got %h expected 00000000", bus.peripheralBus_dataRead); end
        tick();
        bus.peripheralBus_we = 1'b0;
        @(negedge clk);
        n_checks++; if (error_count !== 8'd2) begin n_fail++; $display("FAIL write_noclaim_count: got %0d expected 2", error_count); end
    endtask

    task automatic test_conflict();
        tick();
        bus.peripheralBus_oe = 1'b1;
        device_requestOutput = 4'b1010;
        set_dev(1, 32'h1111_1111);
        set_dev(3, 32'h3333_3333);
        @(negedge clk);
        n_checks++; if (bus.peripheralBus_dataRead !== 32'h1111_1111) begin n_fail++; $display("FAIL conflict_data: got %h expected 11111111", bus.peripheralBus_dataRead); end
        n_checks++; if (bus.bus_error !== 1'b0) begin n_fail++; $display("FAIL conflict_err: got %b expected 0", bus.bus_error); end
        tick();
        bus.peripheralBus_oe = 1'b0;
        device_requestOutput = '0;
        @(negedge clk);
        n_checks++; if (conflict !== 1'b1) begin n_fail++; $display("FAIL conflict_set: got %b expected 1", conflict); end
        tick();
        @(negedge clk);
        n_checks++; if (conflict !== 1'b1) begin n_fail++; $display("FAIL conflict_sticky: got %b expected 1", conflict); end
        // Clear lands in the same cycle as a fresh conflicting claim: clear wins.
        tick();
        bus.peripheralBus_oe = 1'b1;
        device_requestOutput = 4'b1010;
        clear_status = 1'b1;
        tick();
        clear_status = 1'b0;
        bus.peripheralBus_oe = 1'b0;
        device_requestOutput = '0;
        @(negedge clk);
        n_checks++; if (conflict !== 1'b0) begin n_fail++; $display("FAIL clear_conflict: got %b expected 0", conflict); end
        n_checks++; if (error_count !== 8'd0) begin n_fail++; $display("FAIL clear_count: got %0d expected 0", error_count); end
        // Decode error coinciding with clear must also leave the count at 0.
        tick();
        tick();
        bus.peripheralBus_oe = 1'b1;
        clear_status = 1'b1;
        tick();
        clear_status = 1'b0;
        bus.peripheralBus_oe = 1'b0;
        @(negedge clk);
        n_checks++; if (error_count !== 8'd0) begin n_fail++; $display("FAIL clear_priority_count: got %0d expected 0", error_count); end
    endtask

    task automatic test_saturation();
        device_requestOutput = '0;
        for (int k = 0; k < 255; k++) begin
            tick();
            bus.peripheralBus_oe = 1'b1;
            tick();
            bus.peripheralBus_oe = 1'b0;
        end
        @(negedge clk);
        n_checks++; if (error_count !== 8'd255) begin n_fail++; $display("FAIL sat_reach: got %0d expected 255", error_count); end
        for (int k = 0; k < 5; k++) begin
            tick();
            bus.peripheralBus_oe = 1'b1;
            tick();
            bus.peripheralBus_oe = 1'b0;
        end
        @(negedge clk);
        n_checks++; if (error_count !== 8'd255) begin n_fail++; $display("FAIL sat_hold: got %0d expected 255", error_count); end
    endtask

    task automatic test_reset_mid();
        tick();
        bus.peripheralBus_oe = 1'b1;
        device_busy = 4'b0001;
        device_requestOutput = 4'b1100;
        tick();
        @(negedge clk);
        n_checks++; if (bus.peripheralBus_busy !== 1'b1 || conflict !== 1'b1) begin n_fail++; $display("FAIL pre_reset_active: got busy=%b conflict=%b expected busy=1 conflict=1", bus.peripheralBus_busy, conflict); end
        tick();
        rst = 1'b1;
        bus.peripheralBus_oe = 1'b0;
        #1;
        n_checks++; if (bus.peripheralBus_busy !== 1'b0) begin n_fail++; $display("FAIL mid_reset_busy: got %b expected 0", bus.peripheralBus_busy); end
        n_checks++; if (error_count !== 8'd0 || conflict !== 1'b0) begin n_fail++; $display("FAIL mid_reset_status: got count=%0d conflict=%b expected count=0 conflict=0", error_count, conflict); end
        tick();
        rst = 1'b0;
        device_busy = '0;
        device_requestOutput = '0;
        tick();
        bus.peripheralBus_oe = 1'b1;
        device_requestOutput = 4'b0001;
        set_dev(0, 32'h0BAD_F00D);
        @(negedge clk);
        n_checks++; if (bus.peripheralBus_busy !== 1'b0 || bus.bus_error !== 1'b0) begin n_fail++; $display("FAIL post_reset_flags: got busy=%b err=%b expected busy=0 err=0", bus.peripheralBus_busy, bus.bus_error); end
        n_checks++; if (bus.peripheralBus_dataRead !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL post_reset_data: got %h expected 0badf00d", bus.peripheralBus_dataRead); end
        tick();
        bus.peripheralBus_oe = 1'b0;
        device_requestOutput = '0;
        tick();
        @(negedge clk);
        n_checks++; if (error_count !== 8'd0) begin n_fail++; $display("FAIL post_reset_count: got %0d expected 0", error_count); end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_multi_read();
        test_timeout();
        test_decode_error();
        test_conflict();
        test_saturation();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
